// File: rtl/alarm_ring_controller.sv
// Purpose : alarm ring sequencer (match detect, buzzer, snooze, stop, timeout, lockout).
// Latency : every state change is registered, 1 clk after the qualifying input; async reset clears at once.
// Backpressure: none; single-cycle pulse inputs, counters advance only on tick_1hz.
//
// Ports:
//   clk, reset (async active-low)            - clocking
//   tick_1hz                                 - 1 Hz single-cycle pulse
//   cur_hours/minutes/seconds                - running time of day
//   alarm_hours/minutes, alarm_enable        - committed alarm (hours==24 means disabled)
//   btn_snooze, btn_stop                     - debounced single-cycle button pulses
//   ringing, buzzer, snooze_active           - status / drive outputs
//   snooze_count, snooze_left, alarm_event   - snooze bookkeeping, ring-entry pulse
module alarm_ring_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_enable,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       ringing,
  output logic       buzzer,
  output logic       snooze_active,
  output logic [1:0] snooze_count,
  output logic [9:0] snooze_left,
  output logic       alarm_event
);

  localparam logic [5:0] RING_LOAD   = 6'(RING_SECONDS);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MINUTES * 60);
  localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RING    = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snooze_left_q, snooze_left_d;
  logic [1:0] count_q, count_d;
  logic       beep_q, beep_d;
  logic       event_q, event_d;
  // Alarm time captured on entry to RING; any later edit of the alarm aborts the event.
  logic [4:0] evt_hours_q, evt_hours_d;
  logic [5:0] evt_minutes_q, evt_minutes_d;

  logic match;
  logic abort;

  assign match = alarm_enable && (alarm_hours < 5'd24) &&
                 (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes) &&
                 (cur_seconds == 6'd0);

  assign abort = (state_q != IDLE) &&
                 (!alarm_enable || (alarm_hours != evt_hours_q) ||
                  (alarm_minutes != evt_minutes_q));

  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_left_d = snooze_left_q;
    count_d       = count_q;
    beep_d        = beep_q;
    event_d       = 1'b0;
    evt_hours_d   = evt_hours_q;
    evt_minutes_d = evt_minutes_q;

    if (abort) begin
      state_d       = IDLE;
      ring_cnt_d    = '0;
      snooze_left_d = '0;
      count_d       = '0;
      beep_d        = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick_1hz && match) begin
            state_d       = RING;
            ring_cnt_d    = RING_LOAD;
            count_d       = '0;
            beep_d        = 1'b1;
            event_d       = 1'b1;
            evt_hours_d   = alarm_hours;
            evt_minutes_d = alarm_minutes;
          end
        end
        RING: begin
          // A button that is acted on swallows a same-cycle tick; an
          // exhausted snooze request is not acted on, so the tick proceeds.
          if (btn_stop) begin
            state_d = LOCKOUT;
            beep_d  = 1'b0;
          end else if (btn_snooze && (count_q < SNOOZE_MAX)) begin
            state_d       = SNOOZE;
            count_d       = count_q + 2'd1;
            snooze_left_d = SNOOZE_LOAD;
            beep_d        = 1'b0;
          end else if (tick_1hz) begin
            if (ring_cnt_q <= 6'd1) begin
              state_d    = LOCKOUT;
              ring_cnt_d = '0;
              beep_d     = 1'b0;
            end else begin
              ring_cnt_d = ring_cnt_q - 6'd1;
              beep_d     = ~beep_q;
            end
          end
        end
        SNOOZE: begin
          if (btn_stop) begin
            state_d       = LOCKOUT;
            snooze_left_d = '0;
          end else if (tick_1hz) begin
            if (snooze_left_q <= 10'd1) begin
              state_d       = RING;
              snooze_left_d = '0;
              ring_cnt_d    = RING_LOAD;
              beep_d        = 1'b1;
              event_d       = 1'b1;
            end else begin
              snooze_left_d = snooze_left_q - 10'd1;
            end
          end
        end
        LOCKOUT: begin
          // Hold until the clock has left the alarm minute so it cannot retrigger.
          if ((cur_hours != evt_hours_q) || (cur_minutes != evt_minutes_q)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ring_cnt_q    <= '0;
      snooze_left_q <= '0;
      count_q       <= '0;
      beep_q        <= 1'b0;
      event_q       <= 1'b0;
      evt_hours_q   <= '0;
      evt_minutes_q <= '0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_left_q <= snooze_left_d;
      count_q       <= count_d;
      beep_q        <= beep_d;
      event_q       <= event_d;
      evt_hours_q   <= evt_hours_d;
      evt_minutes_q <= evt_minutes_d;
    end
  end

  assign ringing       = (state_q == RING);
  assign buzzer        = ringing & beep_q;
  assign snooze_active = (state_q == SNOOZE);
  assign snooze_count  = count_q;
  assign snooze_left   = snooze_active ? snooze_left_q : 10'd0;
  assign alarm_event   = event_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Purpose : self-checking bench for alarm_ring_controller against a behavioural model.
// Latency : model updates on each rising edge, outputs compared 1 time unit later.
// Backpressure: none.
module tb_alarm_ring_controller;

  localparam int RING_S   = 60;
  localparam int SNOOZE_S = 5 * 60;
  localparam int MAX_SNZ  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic [4:0] alarm_hours = 5'd7;
  logic [5:0] alarm_minutes = 6'd30;
  logic       alarm_enable = 1'b1;
  logic       btn_snooze = 1'b0;
  logic       btn_stop = 1'b0;
  logic       ringing, buzzer, snooze_active, alarm_event;
  logic [1:0] snooze_count;
  logic [9:0] snooze_left;

  int hh = 0, mm = 0, ss = 0;
  int n_cmp = 0, n_bad = 0;

  assign cur_hours   = 5'(hh);
  assign cur_minutes = 6'(mm);
  assign cur_seconds = 6'(ss);

  alarm_ring_controller dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_enable(alarm_enable),
    .btn_snooze(btn_snooze), .btn_stop(btn_stop),
    .ringing(ringing), .buzzer(buzzer), .snooze_active(snooze_active),
    .snooze_count(snooze_count), .snooze_left(snooze_left), .alarm_event(alarm_event)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_vec;
  assign dut_vec = {ringing, buzzer, snooze_active, snooze_count, snooze_left, alarm_event};

  // ---------------- behavioural model ----------------
  bit m_ring, m_snz, m_lock, m_beep, m_event;
  int m_ring_left, m_snz_left, m_count, m_ah, m_am;

  task automatic model_reset();
    m_ring = 0; m_snz = 0; m_lock = 0; m_beep = 0; m_event = 0;
    m_ring_left = 0; m_snz_left = 0; m_count = 0; m_ah = 0; m_am = 0;
  endtask

  task automatic model_start_ring();
    m_ring = 1; m_snz = 0; m_lock = 0;
    m_ring_left = RING_S; m_beep = 1; m_event = 1;
  endtask

  task automatic model_edge();
    bit busy;
    busy = m_ring || m_snz || m_lock;
    m_event = 0;
    if (busy && (!alarm_enable || int'(alarm_hours) != m_ah || int'(alarm_minutes) != m_am)) begin
      m_ring = 0; m_snz = 0; m_lock = 0; m_count = 0;
    end else if (m_ring) begin
      if (btn_stop) begin
        m_ring = 0; m_lock = 1;
      end else if (btn_snooze && m_count < MAX_SNZ) begin
        m_ring = 0; m_snz = 1; m_count++; m_snz_left = SNOOZE_S;
      end else if (tick_1hz) begin
        m_ring_left--;
        m_beep = !m_beep;
        if (m_ring_left == 0) begin m_ring = 0; m_lock = 1; end
      end
    end else if (m_snz) begin
      if (btn_stop) begin
        m_snz = 0; m_lock = 1;
      end else if (tick_1hz) begin
        m_snz_left--;
        if (m_snz_left == 0) model_start_ring();
      end
    end else if (m_lock) begin
      if (hh != m_ah || mm != m_am) m_lock = 0;
    end else begin
      if (tick_1hz && alarm_enable && alarm_hours < 24 && int'(alarm_hours) == hh &&
          int'(alarm_minutes) == mm && ss == 0) begin
        model_start_ring();
        m_count = 0; m_ah = int'(alarm_hours); m_am = int'(alarm_minutes);
      end
    end
  endtask

  function automatic logic [15:0] exp_vec();
    logic [9:0] sl;
    sl = m_snz ? 10'(m_snz_left) : 10'd0;
    return {m_ring, m_ring & m_beep, m_snz, 2'(m_count), sl, m_event};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    tick_1hz = 0; btn_snooze = 0; btn_stop = 0;
  endtask

  task automatic adv_time();
    ss++;
    if (ss == 60) begin
      ss = 0; mm++;
      if (mm == 60) begin mm = 0; hh = (hh + 1) % 24; end
    end
  endtask

  task automatic tick_sec();
    adv_time();
    tick_1hz = 1;
    step();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hh = h; mm = m; ss = s;
  endtask

  task automatic do_reset();
    reset = 0; tick_1hz = 0; btn_snooze = 0; btn_stop = 0;
    alarm_hours = 5'd7; alarm_minutes = 6'd30; alarm_enable = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 0;
    model_reset();
    #2;
    n_cmp++;
    if (dut_vec !== 16'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec, 16'h0);
    end
    do_reset();
    set_time(12, 0, 0);
    step();
    n_cmp++;
    if (dut_vec !== 16'h0) begin
      n_bad++; $display("FAIL post_reset_idle: got %h want %h", dut_vec, 16'h0);
    end
  endtask

  task automatic test_ring_timeout();
    do_reset();
    set_time(7, 29, 58);
    tick_sec();
    n_cmp++;
    if (ringing !== 1'b0) begin n_bad++; $display("FAIL early_ring: got %b want 0", ringing); end
    tick_sec();
    n_cmp++;
    if ({alarm_event, ringing, buzzer} !== 3'b111) begin
      n_bad++; $display("FAIL ring_entry evt/ring/buz: got %b want 111", {alarm_event, ringing, buzzer});
    end
    step();
    n_cmp++;
    if (alarm_event !== 1'b0) begin n_bad++; $display("FAIL event_one_cycle: got %b want 0", alarm_event); end
    for (int k = 1; k < RING_S; k++) begin
      tick_sec();
      n_cmp++;
      if ({ringing, buzzer} !== {1'b1, (k % 2 == 0) ? 1'b1 : 1'b0}) begin
        n_bad++; $display("FAIL buzzer_pattern k=%0d: got %b want %b", k, {ringing, buzzer},
                          {1'b1, (k % 2 == 0) ? 1'b1 : 1'b0});
      end
    end
    tick_sec();
    n_cmp++;
    if ({ringing, snooze_active} !== 2'b00) begin
      n_bad++; $display("FAIL ring_timeout: got %b want 00", {ringing, snooze_active});
    end
    for (int k = 0; k < 5; k++) begin
      tick_sec();
      n_cmp++;
      if (dut_vec !== exp_vec() || ringing !== 1'b0) begin
        n_bad++; $display("FAIL after_timeout: got %h want %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_snooze();
    do_reset();
    set_time(7, 29, 59);
    tick_sec();
    tick_sec();
    btn_snooze = 1;
    step();
    n_cmp++;
    if ({snooze_active, ringing, buzzer, snooze_count, snooze_left} !== {3'b100, 2'd1, 10'd300}) begin
      n_bad++; $display("FAIL snooze_entry: got act=%b ring=%b cnt=%0d left=%0d want 1 0 1 300",
                        snooze_active, ringing, snooze_count, snooze_left);
    end
    for (int k = 1; k < SNOOZE_S; k++) begin
      tick_sec();
      n_cmp++;
      if (snooze_left !== 10'(SNOOZE_S - k) || snooze_active !== 1'b1) begin
        n_bad++; $display("FAIL snooze_countdown k=%0d: got %0d want %0d", k, snooze_left, SNOOZE_S - k);
      end
    end
    tick_sec();
    n_cmp++;
    if ({ringing, alarm_event, snooze_active, snooze_count, snooze_left} !== {3'b110, 2'd1, 10'd0}) begin
      n_bad++; $display("FAIL snooze_rering: got ring=%b evt=%b act=%b cnt=%0d left=%0d want 1 1 0 1 0",
                        ringing, alarm_event, snooze_active, snooze_count, snooze_left);
    end
    btn_stop = 1; btn_snooze = 1;
    step();
    n_cmp++;
    if ({ringing, snooze_active, snooze_count} !== {2'b00, 2'd1}) begin
      n_bad++; $display("FAIL stop_and_snooze: got %b want 0001", {ringing, snooze_active, snooze_count});
    end
  endtask

  task automatic test_snooze_limit();
    do_reset();
    set_time(7, 29, 59);
    tick_sec();
    for (int n = 1; n <= MAX_SNZ; n++) begin
      btn_snooze = 1;
      step();
      repeat (SNOOZE_S) tick_sec();
      n_cmp++;
      if ({ringing, snooze_count} !== {1'b1, 2'(n)}) begin
        n_bad++; $display("FAIL snooze_cycle n=%0d: got ring=%b cnt=%0d want 1 %0d", n, ringing, snooze_count, n);
      end
    end
    btn_snooze = 1;
    step();
    n_cmp++;
    if ({ringing, snooze_active, snooze_count} !== {2'b10, 2'd3}) begin
      n_bad++; $display("FAIL snooze_limit: got ring=%b act=%b cnt=%0d want 1 0 3", ringing, snooze_active, snooze_count);
    end
    btn_snooze = 1;
    tick_sec();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL ignored_snooze_tick: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    set_time(7, 30, 0);
    tick_1hz = 1;
    step();
    btn_stop = 1;
    step();
    tick_1hz = 1;
    step();
    n_cmp++;
    if ({ringing, alarm_event} !== 2'b00) begin
      n_bad++; $display("FAIL same_minute_retrigger: got %b want 00", {ringing, alarm_event});
    end
    set_time(7, 31, 0);
    step();
    set_time(7, 30, 0);
    tick_1hz = 1;
    step();
    n_cmp++;
    if ({ringing, alarm_event} !== 2'b11) begin
      n_bad++; $display("FAIL rearm_after_lockout: got %b want 11", {ringing, alarm_event});
    end
  endtask

  task automatic test_disabled();
    do_reset();
    alarm_hours = 5'd24;
    set_time(7, 29, 55);
    for (int k = 0; k < 20; k++) begin
      tick_sec();
      n_cmp++;
      if (dut_vec !== 16'h0) begin n_bad++; $display("FAIL hours24_idle k=%0d: got %h want 0", k, dut_vec); end
    end
    alarm_hours = 5'd7; alarm_enable = 0;
    set_time(7, 29, 58);
    for (int k = 0; k < 5; k++) begin
      tick_sec();
      n_cmp++;
      if (dut_vec !== 16'h0) begin n_bad++; $display("FAIL enable0_idle k=%0d: got %h want 0", k, dut_vec); end
    end
  endtask

  task automatic test_abort();
    do_reset();
    set_time(7, 29, 59);
    tick_sec();
    btn_snooze = 1;
    step();
    repeat (5) tick_sec();
    alarm_minutes = 6'd45;
    step();
    n_cmp++;
    if (dut_vec !== 16'h0) begin n_bad++; $display("FAIL abort_minutes: got %h want 0", dut_vec); end
    alarm_minutes = 6'd30;
    set_time(7, 29, 59);
    tick_sec();
    alarm_enable = 0;
    step();
    n_cmp++;
    if (dut_vec !== 16'h0) begin n_bad++; $display("FAIL abort_enable: got %h want 0", dut_vec); end
    alarm_enable = 1;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_time(7, 29, 59);
    tick_sec();
    n_cmp++;
    if (buzzer !== 1'b1) begin n_bad++; $display("FAIL pre_reset_buzzer: got %b want 1", buzzer); end
    @(posedge clk);
    model_edge();
    #3 reset = 0;
    model_reset();
    #1;
    n_cmp++;
    if ({ringing, buzzer} !== 2'b00) begin
      n_bad++; $display("FAIL async_reset_drop: got %b want 00", {ringing, buzzer});
    end
    set_time(7, 30, 0);
    @(negedge clk);
    reset = 1;
    repeat (3) step();
    n_cmp++;
    if (ringing !== 1'b0) begin n_bad++; $display("FAIL release_no_tick: got %b want 0", ringing); end
    tick_1hz = 1;
    step();
    n_cmp++;
    if ({ringing, alarm_event} !== 2'b11) begin
      n_bad++; $display("FAIL ring_after_release: got %b want 11", {ringing, alarm_event});
    end
  endtask

  task automatic test_random();
    do_reset();
    set_time(7, 29, 40);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        adv_time();
        tick_1hz = 1;
      end
      if (mm == 32) set_time(7, 29, 50);
      btn_snooze    = ($urandom_range(0, 60) == 0);
      btn_stop      = ($urandom_range(0, 150) == 0);
      alarm_enable  = ($urandom_range(0, 999) != 0);
      alarm_minutes = ($urandom_range(0, 1499) == 0) ? 6'd31 : 6'd30;
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random i=%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    alarm_enable = 1; alarm_minutes = 6'd30;
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_snooze_limit();
    test_retrigger();
    test_disabled();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
